// File: rtl/riscv_v_elastic_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_v_pkg
// Shared constants and helpers for the vector-unit elastic pipeline.
//   RISCV_V_DATA_WIDTH    : default payload width of vector datapath hand-offs
//   riscv_v_occ_width(n)  : width of an occupancy counter able to hold 0..n+1
// -----------------------------------------------------------------------------
package riscv_v_pkg;

    localparam int unsigned RISCV_V_DATA_WIDTH = 32;

    // Sized for up to n stages plus an optional skid entry.
    function automatic int unsigned riscv_v_occ_width(input int unsigned n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/riscv_v_elastic_pipe_if.sv
// -----------------------------------------------------------------------------
// riscv_v_elastic_pipe_if
// One valid/ready/data channel.
//   valid : producer offers data
//   ready : consumer accepts data this cycle
//   data  : payload, DATA_WIDTH bits
// Modports:
//   master : producer side (drives valid/data, observes ready)
//   slave  : consumer side (observes valid/data, drives ready)
// -----------------------------------------------------------------------------
interface riscv_v_elastic_pipe_if
    import riscv_v_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RISCV_V_DATA_WIDTH
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/riscv_v_elastic_pipe_skid.sv
// -----------------------------------------------------------------------------
// riscv_v_elastic_skid
// One-entry skid register placed after the last pipeline stage. It captures
// the last stage's entry when the sink stalls, so the stage chain sees a
// registered ready and in_ready has no combinational path from out_ready.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   flush       : synchronous discard of the held entry
//   up_valid    : last pipeline stage holds an entry
//   up_data     : last pipeline stage payload
//   out_ready   : downstream accepts the current output
//   skid_valid  : skid holds an entry (registered)
//   skid_data   : skid payload (registered)
// -----------------------------------------------------------------------------
module riscv_v_elastic_skid
    import riscv_v_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = RISCV_V_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  out_ready,
    output logic                  skid_valid,
    output logic [DATA_WIDTH-1:0] skid_data
);

    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid is the output source while occupied; it empties on a transfer.
            if (out_ready) begin
                skid_valid_d = 1'b0;
            end
        end else if (up_valid && !out_ready) begin
            // Sink stalled while skid is free: the last stage drains into skid.
            skid_valid_d = 1'b1;
            skid_data_d  = up_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= RST_VAL;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign skid_valid = skid_valid_q;
    assign skid_data  = skid_data_q;

endmodule

// File: rtl/riscv_v_elastic_pipe.sv
// -----------------------------------------------------------------------------
// riscv_v_elastic_pipe
// Flow-controlled NUM_STAGES-deep pipeline delay with per-stage valid bits, so
// bubbles collapse under back-pressure. Strict FIFO order; flush discards all
// in-flight entries.
// Optional feature: define RISCV_V_ELASTIC_PIPE_SKID_EN to add a one-entry skid
// register after the last stage (capacity NUM_STAGES+1, in_ready registered
// with respect to out_ready).
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   flush     : synchronous discard; blocks both ends in the flush cycle
//   in_if     : upstream channel (slave): in valid/data, out ready
//   out_if    : downstream channel (master): out valid/data, in ready
//   occupancy : number of valid entries, including the skid entry
// -----------------------------------------------------------------------------
module riscv_v_elastic_pipe
    import riscv_v_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = RISCV_V_DATA_WIDTH,
    parameter int unsigned           NUM_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    riscv_v_elastic_pipe_if.slave                    in_if,
    riscv_v_elastic_pipe_if.master                   out_if,
    output logic [riscv_v_occ_width(NUM_STAGES)-1:0] occupancy
);

    localparam int unsigned OCC_W = riscv_v_occ_width(NUM_STAGES);

    logic [NUM_STAGES-1:0] valid_vec;
    logic [NUM_STAGES-1:0] stage_ready;
    logic [DATA_WIDTH-1:0] data_vec [NUM_STAGES];
    logic                  sink_ready;
    logic                  skid_occ;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        logic                  valid_q, valid_d;
        logic [DATA_WIDTH-1:0] data_q,  data_d;
        logic                  src_valid;
        logic [DATA_WIDTH-1:0] src_data;

        if (i == 0) begin : g_src_in
            assign src_valid = in_if.valid;
            assign src_data  = in_if.data;
        end else begin : g_src_stage
            assign src_valid = valid_vec[i-1];
            assign src_data  = data_vec[i-1];
        end

        // Unrolled ready chain: a stage can advance unless it and every stage
        // after it are full while the sink is stalled.
        assign stage_ready[i] = sink_ready || !(&valid_vec[NUM_STAGES-1:i]);

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (flush) begin
                valid_d = 1'b0;
            end else if (stage_ready[i]) begin
                valid_d = src_valid;
                // Data only captures real entries; bubbles leave it untouched.
                if (src_valid) begin
                    data_d = src_data;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= 1'b0;
                data_q  <= RST_VAL;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign valid_vec[i] = valid_q;
        assign data_vec[i]  = data_q;
    end

    assign in_if.ready = stage_ready[0] && !flush;

`ifdef RISCV_V_ELASTIC_PIPE_SKID_EN
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;

    riscv_v_elastic_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .RST_VAL    (RST_VAL)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .up_valid   (valid_vec[NUM_STAGES-1]),
        .up_data    (data_vec[NUM_STAGES-1]),
        .out_ready  (out_if.ready),
        .skid_valid (skid_valid),
        .skid_data  (skid_data)
    );

    // Registered sink ready: the last stage may always move while skid is free.
    assign sink_ready   = !skid_valid;
    assign out_if.valid = (skid_valid || valid_vec[NUM_STAGES-1]) && !flush;
    assign out_if.data  = skid_valid ? skid_data : data_vec[NUM_STAGES-1];
    assign skid_occ     = skid_valid;
`else
    assign sink_ready   = out_if.ready;
    assign out_if.valid = valid_vec[NUM_STAGES-1] && !flush;
    assign out_if.data  = data_vec[NUM_STAGES-1];
    assign skid_occ     = 1'b0;
`endif

    always_comb begin
        occupancy = OCC_W'(skid_occ);
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            occupancy = occupancy + OCC_W'(valid_vec[i]);
        end
    end

endmodule

// File: doc/riscv_v_elastic_pipe.md
# riscv_v_elastic_pipe

Parametrised, flow-controlled pipeline delay for vector-unit datapaths. It moves a `DATA_WIDTH` payload through `NUM_STAGES` registers using a valid/ready handshake. Each stage has its own valid bit, so bubbles collapse under back-pressure, and a synchronous flush discards in-flight data. It sits between vector execution sub-units (operand fetch → lane ALU → writeback) wherever a fixed-latency enable-driven stage cannot tolerate downstream stalls.

## Interface
- `DATA_WIDTH`, default `riscv_v_pkg::RISCV_V_DATA_WIDTH`: payload width in bits, ≥1.
- `NUM_STAGES`, default 2: register stages, ≥1.
- `RST_VAL`, default `'0`: reset value of every data register.

- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous discard of all in-flight entries.
- `in_valid` input 1: upstream offers `in_data`.
- `in_ready` output 1: pipe accepts `in_data` this cycle.
- `in_data` input `DATA_WIDTH`: upstream payload.
- `out_valid` output 1: `out_data` holds a valid entry.
- `out_ready` input 1: downstream accepts `out_data`.
- `out_data` output `DATA_WIDTH`: oldest entry.
- `occupancy` output `$clog2(NUM_STAGES+2)`: count of valid entries, including the skid entry when present.

## Operation
- Stage i (1..N) holds `valid[i]` and `data[i]`. Stage 1 takes input; stage N feeds the output, or the skid stage when that is compiled in.
- Transfers:
  - An input transfer happens when `in_valid && in_ready`.
  - An output transfer happens when `out_valid && out_ready`.
- Stage ready: `ready[N] = sink_ready || !valid[N]` and `ready[i] = ready[i+1] || !valid[i]`. `in_ready = ready[1]`.
- When `ready[i]` is high, stage i loads from stage i-1, meaning `in_data`/`in_valid` for i=1. The source valid is cleared when it moves and nothing replaces it. When `ready[i]` is low, stage i holds.
- Data registers load only when the incoming valid is 1. Otherwise they hold, so no toggling on bubbles.
- Order is strictly FIFO. No entry is dropped or duplicated except by flush.
- Flush (priority below reset):
  - In the flush cycle, `in_ready` and `out_valid` are forced to 0. No transfer occurs at either end.
  - All valid bits clear at the next edge. Data registers hold.
- Reset: all valids are 0 and all data registers equal `RST_VAL`. Hence `out_valid=0`, `out_data=RST_VAL`, `in_ready=1` (unless flush is high), and `occupancy=0`.
- `occupancy` is the popcount of the valid bits, combinational from registers.

## Timing
- Latency from input transfer to `out_valid` is N cycles with no stall, in both configurations.
- Throughput is one transfer per cycle sustained when `out_ready=1`.
- Without skid, `in_ready` depends combinationally on `out_ready` through the ready chain.
- Capacity is N entries, or N+1 with skid. `in_ready` goes low only when every stage is valid and the sink is not ready.
- Simultaneous input and output transfers when full are legal and keep occupancy constant.
- Reset assertion mid-operation takes effect immediately (asynchronous). Deassertion is synchronous to `clk` by the external reset synchroniser.

## Configuration
- Macro: `RISCV_V_ELASTIC_PIPE_SKID_EN`.
- Defined: a one-entry skid register follows stage N, with `sink_ready = !skid_valid` (registered).
  - If `valid[N] && !out_ready && !skid_valid`, `data[N]` moves into skid.
  - `out_valid = skid_valid || valid[N]`.
  - `out_data = skid_valid ? skid_data : data[N]`.
  - Skid clears on an output transfer.
  - `in_ready` has no combinational path from `out_ready`.
  - Flush and reset clear `skid_valid`; reset also sets the skid data to `RST_VAL`.
- Undefined: `sink_ready = out_ready`, `out_valid = valid[N]`, `out_data = data[N]`. No skid logic exists.

## Structure
- `riscv_v_pkg` provides `RISCV_V_DATA_WIDTH` and a `riscv_v_occ_width(n)` function returning `$clog2(n+2)`.
- One sub-module, `riscv_v_elastic_skid`, implements the skid entry. It is instantiated only under the macro.
- Stages are built with a generate loop in the top module.

## Test plan
All cases use `NUM_STAGES=3`, `DATA_WIDTH=32`, `RST_VAL=32'hDEAD_BEEF`.
1. Stream 0x1..0x8 with `in_valid=1` and `out_ready=1`. First `out_valid` appears 3 cycles after the first accept. Output is 0x1..0x8 on consecutive cycles and occupancy stays at 3.
2. Hold `out_ready=0` and offer 0x10..0x15. `in_ready` drops after 3 accepts (4 with skid) and occupancy reads 3/4. Release `out_ready`: output is 0x10..0x15 in order with no loss.
3. Bubble collapse: send 0xA, wait 2 cycles, hold `out_ready=0`, send 0xB. 0xB advances to stage 2 while 0xA waits in stage 3, and `in_ready` stays 1 until full.
4. Pulse `flush` at occupancy 2 with `in_valid=1`, `in_data=0x77`. `in_ready=0` and `out_valid=0` in the flush cycle. Next cycle: occupancy 0 and 0x77 never appears at the output.
5. Drive `rst=0` asynchronously mid-stream. `out_valid=0` and `out_data=0xDEADBEEF` appear before the next edge. After release, stream 0x1..0x3 behaves as in case 1.
6. Build with `RISCV_V_ELASTIC_PIPE_SKID_EN` and toggle `out_ready` every cycle, with a random glitch mid-cycle. `in_ready` never changes within a cycle, order is preserved, and throughput is 50%.
